// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID-stage request and forward/stall response bundle for fwd_hazard_unit
interface fwd_hazard_unit_if;
    logic        ID_valid_in;
    logic [4:0]  ID_rs_in;
    logic [4:0]  ID_rt_in;
    logic [4:0]  ID_rd_in;
    logic        ID_RegWrite_in;
    logic        ID_MemRead_in;
    logic        Flush_in;
    logic [1:0]  Forward_A_out;
    logic [1:0]  Forward_B_out;
    logic        Stall_out;
    logic        EX_bubble_out;
    logic [15:0] Stall_count_out;

    modport master (
        output ID_valid_in, ID_rs_in, ID_rt_in, ID_rd_in, ID_RegWrite_in, ID_MemRead_in, Flush_in,
        input  Forward_A_out, Forward_B_out, Stall_out, EX_bubble_out, Stall_count_out
    );

    modport slave (
        input  ID_valid_in, ID_rs_in, ID_rt_in, ID_rd_in, ID_RegWrite_in, ID_MemRead_in, Flush_in,
        output Forward_A_out, Forward_B_out, Stall_out, EX_bubble_out, Stall_count_out
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use stall unit; FWD_HAZARD_STATS_EN adds a saturating stall counter
module fwd_hazard_unit (
    input  logic               clk_in,
    input  logic               rst_in,
    fwd_hazard_unit_if.slave   bus
);
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rd;
    } trk_t;

    typedef enum logic {
        RUN     = 1'b0,
        LOADUSE = 1'b1
    } state_t;

    trk_t   id_ex;
    trk_t   ex_mem;
    trk_t   mem_wb;
    trk_t   id_entry;
    state_t state;

    logic       hazard;
    logic       stall;
    logic       bubble_in;
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;
    logic       ex_bubble_q;

    // A tracker supplies a forward only if it really writes a non-zero register equal to src
    function automatic logic writes_reg(input trk_t t, input logic [4:0] src);
        return t.valid & t.reg_write & (t.rd != 5'd0) & (t.rd == src);
    endfunction

    // The younger producer (currently in EX, next in MEM) wins over the older one
    function automatic logic [1:0] fwd_code(input trk_t young, input trk_t old, input logic [4:0] src);
        if (writes_reg(young, src))
            return 2'b10;
        else if (writes_reg(old, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Load-use detection and the decision whether ID enters EX as a bubble
    always_comb begin
        hazard = bus.ID_valid_in & id_ex.valid & id_ex.mem_read & (id_ex.rd != 5'd0) &
                 ((id_ex.rd == bus.ID_rs_in) | (id_ex.rd == bus.ID_rt_in));
        stall = hazard & ~bus.Flush_in & ~rst_in & (state == RUN);
        bubble_in = stall | bus.Flush_in | ~bus.ID_valid_in;
        id_entry.valid     = bus.ID_valid_in;
        id_entry.reg_write = bus.ID_RegWrite_in;
        id_entry.mem_read  = bus.ID_MemRead_in;
        id_entry.rd        = bus.ID_rd_in;
    end

    // Destination trackers shift every edge; forward codes register as ID enters EX
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            ex_bubble_q <= 1'b1;
        end else begin
            mem_wb <= ex_mem;
            ex_mem <= id_ex;
            if (bubble_in) begin
                id_ex       <= '0;
                fwd_a_q     <= 2'b00;
                fwd_b_q     <= 2'b00;
                ex_bubble_q <= 1'b1;
            end else begin
                id_ex       <= id_entry;
                fwd_a_q     <= fwd_code(id_ex, ex_mem, bus.ID_rs_in);
                fwd_b_q     <= fwd_code(id_ex, ex_mem, bus.ID_rt_in);
                ex_bubble_q <= 1'b0;
            end
        end
    end

    // Stall FSM: a stall lasts exactly one cycle, never back-to-back
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (stall) state <= LOADUSE;
                LOADUSE: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // The WB destination is tracked for pipeline completeness; the register file bypasses WB itself
    logic mem_wb_unused;
    assign mem_wb_unused = ^mem_wb;

`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of load-use stall edges
    always_ff @(posedge clk_in) begin
        if (rst_in)
            stall_cnt_q <= 16'd0;
        else if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign bus.Stall_count_out = stall_cnt_q;
`else
    assign bus.Stall_count_out = 16'd0;
`endif

    assign bus.Stall_out     = stall;
    assign bus.Forward_A_out = fwd_a_q;
    assign bus.Forward_B_out = fwd_b_q;
    assign bus.EX_bubble_out = ex_bubble_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit against an EX-entry history model
module tb_fwd_hazard_unit;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    fwd_hazard_unit_if bus ();

    fwd_hazard_unit dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit       valid;
        bit       rw;
        bit       mr;
        bit [4:0] rd;
    } ins_t;

    localparam int HMAX = 8192;

    ins_t hist [HMAX];
    int   n_edges;
    bit   prev_stall;
    int   stall_total;
    int   exp_fa;
    int   exp_fb;
    int   exp_bub;
    int   exp_cnt;
    int   errors = 0;
    int   checks = 0;
    bit   last_stall;

    function automatic ins_t bubble();
        ins_t b;
        b.valid = 0; b.rw = 0; b.mr = 0; b.rd = 0;
        return b;
    endfunction

    function automatic bit produces(ins_t p, bit [4:0] r);
        return p.valid && p.rw && p.rd != 0 && p.rd == r;
    endfunction

    function automatic int model_stall(bit rst, bit v, bit [4:0] rs, bit [4:0] rt, bit fl);
        ins_t p;
        if (rst || prev_stall || fl || !v) return 0;
        p = hist[n_edges - 1];
        return (p.valid && p.mr && p.rd != 0 && (p.rd == rs || p.rd == rt)) ? 1 : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit rw, bit mr, bit fl, bit rst);
        int   s;
        int   fa;
        int   fb;
        ins_t p1;
        ins_t p2;
        ins_t e;
        bus.ID_valid_in    = v;
        bus.ID_rs_in       = rs;
        bus.ID_rt_in       = rt;
        bus.ID_rd_in       = rd;
        bus.ID_RegWrite_in = rw;
        bus.ID_MemRead_in  = mr;
        bus.Flush_in       = fl;
        rst_in             = rst;
        #1;
        s = model_stall(rst, v, rs, rt, fl);
        check("stall", int'(bus.Stall_out), s);
        last_stall = bus.Stall_out;
        @(posedge clk_in);
        if (rst) begin
            hist[n_edges]     = bubble();
            hist[n_edges - 1] = bubble();
            exp_fa = 0; exp_fb = 0; exp_bub = 1;
            stall_total = 0;
            prev_stall = 0;
        end else begin
            p1 = hist[n_edges - 1];
            p2 = hist[n_edges - 2];
            if (s == 1 || fl || !v) begin
                e = bubble();
                exp_fa = 0; exp_fb = 0; exp_bub = 1;
            end else begin
                e.valid = 1; e.rw = rw; e.mr = mr; e.rd = rd;
                fa = produces(p1, rs) ? 2 : (produces(p2, rs) ? 1 : 0);
                fb = produces(p1, rt) ? 2 : (produces(p2, rt) ? 1 : 0);
                exp_fa = fa; exp_fb = fb; exp_bub = 0;
            end
            hist[n_edges] = e;
            if (s == 1 && stall_total < 65535) stall_total++;
            prev_stall = (s == 1);
        end
        n_edges++;
`ifdef FWD_HAZARD_STATS_EN
        exp_cnt = stall_total;
`else
        exp_cnt = 0;
`endif
        @(negedge clk_in);
        check("fwd_a", int'(bus.Forward_A_out), exp_fa);
        check("fwd_b", int'(bus.Forward_B_out), exp_fb);
        check("ex_bubble", int'(bus.EX_bubble_out), exp_bub);
        check("stall_count", int'(bus.Stall_count_out), exp_cnt);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        rst_in = 1'b0;
    endtask

    initial begin
        bit       v;
        bit       fl;
        bit       rs_;
        bit [4:0] a;
        bit [4:0] b;
        bit [4:0] d;
        for (int i = 0; i < HMAX; i++) hist[i] = bubble();
        n_edges = 2;
        prev_stall = 0;
        stall_total = 0;
        exp_cnt = 0;
        @(negedge clk_in);
        do_reset();
        check("reset_fa_lit", int'(bus.Forward_A_out), 0);
        check("reset_bub_lit", int'(bus.EX_bubble_out), 1);
        check("reset_cnt_lit", int'(bus.Stall_count_out), 0);

        // add r3 ; sub rs=r3
        step(1, 1, 2, 3, 1, 0, 0, 0);
        step(1, 3, 1, 6, 1, 0, 0, 0);
        check("ex_to_ex_lit", int'(bus.Forward_A_out), 2);

        // add r3 ; nop ; and rt=r3
        step(1, 1, 2, 3, 1, 0, 0, 0);
        nop();
        step(1, 7, 3, 8, 1, 0, 0, 0);
        check("mem_to_ex_lit", int'(bus.Forward_B_out), 1);

        // lw r5 ; add rs=r5 (stall, bubble, then 01)
        do_reset();
        step(1, 0, 0, 5, 1, 1, 0, 0);
        step(1, 5, 2, 9, 1, 0, 0, 0);
        check("load_use_stall_lit", int'(last_stall), 1);
        check("load_use_bubble_lit", int'(bus.EX_bubble_out), 1);
        step(1, 5, 2, 9, 1, 0, 0, 0);
        check("load_use_restall_lit", int'(last_stall), 0);
        check("load_use_fwd_lit", int'(bus.Forward_A_out), 1);
`ifdef FWD_HAZARD_STATS_EN
        check("load_use_count_lit", int'(bus.Stall_count_out), 1);
`endif

        // writer to r0 ; reader r0,r0
        step(1, 1, 2, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0);
        check("r0_a_lit", int'(bus.Forward_A_out), 0);
        check("r0_b_lit", int'(bus.Forward_B_out), 0);

        // add r4 ; sub r4 ; or rs=r4
        step(1, 1, 2, 4, 1, 0, 0, 0);
        step(1, 1, 2, 4, 1, 0, 0, 0);
        step(1, 4, 1, 10, 1, 0, 0, 0);
        check("youngest_lit", int'(bus.Forward_A_out), 2);

        // lw r5 ; dependent add flushed
        step(1, 0, 0, 5, 1, 1, 0, 0);
        step(1, 5, 0, 9, 1, 0, 1, 0);
        check("flush_no_stall_lit", int'(last_stall), 0);

        // reset in the middle of a load-use stall
        step(1, 0, 0, 5, 1, 1, 0, 0);
        step(1, 5, 0, 9, 1, 0, 0, 0);
        check("pre_reset_stall_lit", int'(last_stall), 1);
        step(1, 5, 0, 9, 1, 0, 0, 1);
        check("mid_reset_stall_lit", int'(last_stall), 0);
        check("mid_reset_fa_lit", int'(bus.Forward_A_out), 0);
        check("mid_reset_bub_lit", int'(bus.EX_bubble_out), 1);
        check("mid_reset_cnt_lit", int'(bus.Stall_count_out), 0);
        rst_in = 1'b0;
        step(1, 5, 0, 9, 1, 0, 0, 0);
        check("post_reset_no_stall_lit", int'(last_stall), 0);

        // Randomised traffic over a small register window to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            v   = ($urandom_range(0, 7) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            rs_ = ($urandom_range(0, 63) == 0);
            a   = 5'($urandom_range(0, 3));
            b   = 5'($urandom_range(0, 3));
            d   = 5'($urandom_range(0, 3));
            step(v, a, b, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fl, rs_);
            if (n_edges >= HMAX - 4) break;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk_in and rst_in.
REQ-002 clk_in  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous active-high reset.
REQ-004 ID_valid_in  input  1  instruction in ID is real (not a bubble).
REQ-005 ID_rs_in, ID_rt_in  input  5 each  source register numbers of the ID instruction.
REQ-006 ID_rd_in  input  5  destination register number of the ID instruction.
REQ-007 ID_RegWrite_in  input  1  ID instruction writes ID_rd_in.
REQ-008 ID_MemRead_in  input  1  ID instruction is a load.
REQ-009 Flush_in  input  1  discard the ID instruction (taken branch/jump).
REQ-010 Forward_A_out, Forward_B_out  output  2 each  operand-select codes for the EX-stage instruction: 00 register data, 01 MEM_WB result, 10 EX_MEM result; 11 never driven.
REQ-011 Stall_out  output  1  hold PC and IF/ID this cycle.
REQ-012 EX_bubble_out  output  1  EX stage holds a bubble this cycle.
REQ-013 Stall_count_out  output  16  load-use stall count (see Configuration).

Function
REQ-014 Three internal destination trackers SHALL exist: ID_EX, EX_MEM, MEM_WB, each holding {valid, RegWrite, MemRead, rd}.
REQ-015 Each rising edge with no stall SHALL shift: ID inputs -> ID_EX -> EX_MEM -> MEM_WB.
REQ-016 Load-use hazard (combinational) SHALL be: ID_valid_in & ID_EX.valid & ID_EX.MemRead & ID_EX.rd!=0 & (ID_EX.rd==ID_rs_in | ID_EX.rd==ID_rt_in).
REQ-017 Stall_out SHALL equal the load-use hazard AND NOT Flush_in, in the same cycle (zero latency).
REQ-018 On a stall edge, ID_EX SHALL load a bubble (all fields 0), while ID_EX->EX_MEM->MEM_WB still shifts.
REQ-019 On Flush_in=1, ID_EX SHALL load a bubble; flush overrides stall.
REQ-020 Forward_A_out SHALL be registered, computed at the edge the ID instruction enters EX: 10 if ID_EX.valid & ID_EX.RegWrite & ID_EX.rd!=0 & ID_EX.rd==ID_rs_in; else 01 if the same test against EX_MEM; else 00.
REQ-021 Forward_B_out SHALL follow REQ-020 using ID_rt_in.
REQ-022 EX_MEM match SHALL take priority over MEM_WB match.
REQ-023 Register 0 SHALL never produce a forward code.
REQ-024 When a bubble enters EX (stall, flush, or ID_valid_in=0), both forward outputs SHALL register 00 and EX_bubble_out SHALL register 1.
REQ-025 The stall FSM SHALL have states RUN and LOADUSE: RUN->LOADUSE on a stall edge; LOADUSE->RUN unconditionally next edge; a stall SHALL NOT be asserted in LOADUSE.
REQ-026 After a one-cycle load-use stall, the re-presented instruction SHALL receive code 01 for the load operand.
REQ-027 WB-to-ID same-cycle bypass SHALL remain in the register file, outside this block.

Reset
REQ-028 With rst_in=1 at an edge, all trackers SHALL clear to bubbles, FSM->RUN, Forward_A_out=Forward_B_out=00, EX_bubble_out=1, Stall_count_out=0.
REQ-029 Stall_out SHALL be 0 while rst_in=1.
REQ-030 Reset during LOADUSE SHALL abandon the stall with no residual bubble or count.

Configuration
REQ-031 Macro FWD_HAZARD_STATS_EN defined: Stall_count_out SHALL increment by 1 each stall edge and saturate at 16'hFFFF.
REQ-032 Macro FWD_HAZARD_STATS_EN undefined: Stall_count_out SHALL be constant 0 and no counter logic SHALL exist; all other behaviour unchanged.

Verification
REQ-033 add r3 in ID, then sub rs=r3 next -> Forward_A_out=10 on the sub's EX cycle.
REQ-034 add r3, nop, then and rt=r3 -> Forward_B_out=01 on the and's EX cycle.
REQ-035 lw r5, then add rs=r5 -> Stall_out=1 one cycle, EX_bubble_out=1 next cycle, then Forward_A_out=01; Stall_count_out=1 with STATS_EN.
REQ-036 Writer to r0, then reader rs=rt=r0 -> both forward codes 00.
REQ-037 add r4 then sub r4 then or rs=r4 -> Forward_A_out=10 (youngest wins).
REQ-038 lw r5 / dependent add with Flush_in=1 -> Stall_out=0; rst_in mid-LOADUSE -> outputs at REQ-028 values next edge.
